// File: rtl/mine_placer.sv
// mine_placer: fills a CELLS-cell mine map with exactly MINES distinct mines
// when a placement is requested, then pulses out_place_done for one cycle.
// Randomness comes from a free-running 9-bit Fibonacci LFSR. Candidates that
// fall off the board or hit an existing mine are rejected and redrawn.
// Optional feature macro: MINE_SAFE_CELL_EN adds the in_safe port; that cell is
// never mined, which gives first-click safety.
module mine_placer #(
    parameter int         CELLS = 9,
    parameter int         MINES = 3,
    parameter logic [8:0] SEED  = 9'h1A5
) (
    input  logic             in_clka,
    input  logic             in_restart_n,
    input  logic             in_place,
`ifdef MINE_SAFE_CELL_EN
    input  logic [3:0]       in_safe,
`endif
    output logic [CELLS-1:0] out_mines,
    output logic             out_place_done,
    output logic             out_busy,
    output logic [3:0]       out_count
);

    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [8:0] SEED_INIT = (SEED == 9'd0) ? 9'h001 : SEED;
    localparam logic [4:0] CELLS_LIM = 5'(CELLS);
    localparam logic [3:0] MINES_TGT = 4'(MINES);

    state_t           state_reg, state_next;
    logic [8:0]       lfsr_reg, lfsr_next;
    logic [CELLS-1:0] mines_reg, mines_next;
    logic [3:0]       count_reg, count_next;

    logic [3:0]       cand;
    logic [15:0]      map_ext;
    logic [CELLS-1:0] cand_hot;
    logic             cand_ok;
    logic             safe_ok;
    logic             accept;

    // The candidate is the low nibble of the current (pre-shift) LFSR value.
    assign cand = lfsr_reg[3:0];

    // Pad the map to 16 entries so any nibble can index it; off-board
    // entries read as empty but are rejected by the range test anyway.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_ext
            if (gi < CELLS) begin : g_cell
                assign map_ext[gi] = mines_reg[gi];
            end else begin : g_pad
                assign map_ext[gi] = 1'b0;
            end
        end
        for (gi = 0; gi < CELLS; gi++) begin : g_hot
            assign cand_hot[gi] = (cand == 4'(gi));
        end
    endgenerate

    assign cand_ok = ({1'b0, cand} < CELLS_LIM) && !map_ext[cand];

`ifdef MINE_SAFE_CELL_EN
    // A safe index at or beyond CELLS never matches an on-board candidate.
    assign safe_ok = (cand != in_safe);
`else
    assign safe_ok = 1'b1;
`endif

    assign accept = (state_reg == DRAW) && cand_ok && safe_ok;

    // State, LFSR and map registers; reset clears the map immediately.
    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state_reg <= IDLE;
            lfsr_reg  <= SEED_INIT;
            mines_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            mines_reg <= mines_next;
            count_reg <= count_next;
        end
    end

    // Next-state logic: LFSR always advances, map changes only in CLEAR/DRAW.
    always_comb begin
        state_next = state_reg;
        lfsr_next  = {lfsr_reg[7:0], lfsr_reg[8] ^ lfsr_reg[4]};
        mines_next = mines_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (in_place) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                mines_next = '0;
                count_next = '0;
                state_next = DRAW;
            end
            DRAW: begin
                if (accept) begin
                    mines_next = mines_reg | cand_hot;
                    count_next = count_reg + 4'd1;
                    if (count_reg + 4'd1 == MINES_TGT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign out_mines      = mines_reg;
    assign out_count      = count_reg;
    assign out_busy       = (state_reg == CLEAR) || (state_reg == DRAW);
    assign out_place_done = (state_reg == DONE);

endmodule

// File: tb/tb_mine_placer.sv
// Testbench for mine_placer. Stimulus pushes the expected result of each
// placement into a queue; a monitor pops and compares on every done pulse.
module tb_mine_placer;

    localparam int CELLS = 9;
    localparam int MINES = 3;
    localparam int WAIT_LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       place = 1'b0;
`ifdef MINE_SAFE_CELL_EN
    logic [3:0] safe = 4'd4;
`endif
    logic [8:0] mines;
    logic       done;
    logic       busy;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int txn = 0;

    typedef struct {
        logic [8:0] mines;
        bit         exact;
        int         lat;
        int         req_cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    mine_placer #(.CELLS(CELLS), .MINES(MINES), .SEED(9'h1A5)) dut (
        .in_clka        (clk),
        .in_restart_n   (rst_n),
        .in_place       (place),
`ifdef MINE_SAFE_CELL_EN
        .in_safe        (safe),
`endif
        .out_mines      (mines),
        .out_place_done (done),
        .out_busy       (busy),
        .out_count      (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: one comparison set per done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            txn++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = q.pop_front();
                $display("txn %0d: map=0x%03h count=%0d lat=%0d", txn, mines, count,
                         (mon_e.req_cyc >= 0) ? cyc - mon_e.req_cyc : -1);
                check("done_count", int'(count), MINES);
                check("done_popcount", $countones(mines), MINES);
`ifdef MINE_SAFE_CELL_EN
                check("safe_cell_clear", int'(mines[4]), 0);
`endif
                if (mon_e.exact) begin
                    check("done_map", int'(mines), int'(mon_e.mines));
                    check("done_latency", cyc - mon_e.req_cyc, mon_e.lat);
                end else if (mon_e.req_cyc >= 0) begin
                    check("latency_min", int'((cyc - mon_e.req_cyc) >= MINES + 2), 1);
                end
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!done && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in %0d cycles expected a pulse", WAIT_LIMIT);
        end
    endtask

    // Reset, release, wait k cycles, then request one placement.
    task automatic start_run(input int k, input logic [8:0] exp_map, input int exp_lat);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (k) @(negedge clk);
        place = 1'b1;
        e.mines = exp_map;
        e.exact = 1'b1;
        e.lat = exp_lat;
        e.req_cyc = cyc;
        q.push_back(e);
        @(negedge clk);
        place = 1'b0;
        check("busy_after_request", int'(busy), 1);
    endtask

    // Held request: n back-to-back placements, map cleared between them.
    task automatic held_run(input int n);
        exp_t e;
        e.mines = '0;
        e.exact = 1'b0;
        e.lat = 0;
        e.req_cyc = -1;
        repeat (n) q.push_back(e);
        place = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_done();
            if (i == n - 1) begin
                place = 1'b0;
            end else begin
                repeat (3) @(negedge clk);
                check("clear_between_map", int'(mines), 0);
                check("clear_between_count", int'(count), 0);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        int n;
        logic [8:0] map_a, map_b;
        int lat_a, lat_b;
`ifdef MINE_SAFE_CELL_EN
        map_a = 9'h182; lat_a = 13;
        map_b = 9'h106; lat_b = 13;
`else
        map_a = 9'h190; lat_a = 12;
        map_b = 9'h112; lat_b = 12;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        check("reset_mines", int'(mines), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_count", int'(count), 0);

        // Idle with no request: nothing moves
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (mines != 0 || done || busy || count != 0) bad = 1'b1;
        end
        check("idle_quiet", int'(bad), 0);

        // Request right at reset release, exact hand-computed map
        start_run(0, map_a, lat_a);
        wait_done();

        // Request only during DONE must be ignored
        place = 1'b1;
        @(negedge clk);
        place = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy) bad = 1'b1;
        end
        check("place_in_done_ignored", int'(bad), 0);

        // Request one cycle later gives a different map
        start_run(1, map_b, lat_b);
        wait_done();

        // Reset mid-DRAW once one mine is placed
        start_run(0, map_a, lat_a);
        n = 0;
        while (count != 4'd1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("reach_count_one", int'(count), 1);
        rst_n = 1'b0;
        #1;
        check("midreset_mines", int'(mines), 0);
        check("midreset_count", int'(count), 0);
        check("midreset_busy", int'(busy), 0);
        void'(q.pop_front());
        repeat (3) @(negedge clk);
        check("midreset_no_done", int'(done), 0);

        // Same request timing after reset reproduces the same map
        start_run(0, map_a, lat_a);
        wait_done();
        @(negedge clk);

        // Continuous request: back-to-back placements
        held_run(3);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy) bad = 1'b1;
        end
        check("held_release_idle", int'(bad), 0);

`ifdef MINE_SAFE_CELL_EN
        // Many placements with cell 4 protected
        held_run(200);
`endif

        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mine_placer.md
# mine_placer

Upstream stage of the minesweeper core: on a place request it fills a 3x3 mine map and hands it to the main FSM. It drives the mine vector that the main FSM latches during its place state. A free-running 9-bit LFSR supplies the randomness, so the resulting layout depends on the cycle at which the request arrives. Rejection sampling guarantees exactly MINES distinct mines on valid cells.

## Interface
- CELLS, 9: board cells. Legal range 2..15.
- MINES, 3: mines to place. Legal range 1..CELLS-1.
- SEED, 9'h1A5: LFSR value loaded at reset. A value of 0 is replaced by 9'h001.
- in_clka  input  1  sole clock; all state updates on the rising edge.
- in_restart_n  input  1  asynchronous, active-low reset.
- in_place  input  1  placement request; sampled only in IDLE.
- in_safe  input  4  cell index that must stay mine-free. Present only with MINE_SAFE_CELL_EN.
- out_mines  output  CELLS  mine map; bit i=1 means mine at cell i.
- out_place_done  output  1  one-cycle pulse when the map is complete.
- out_busy  output  1  high in CLEAR and DRAW.
- out_count  output  4  mines placed so far.

## Operation
- LFSR: 9-bit Fibonacci register.
  - Each cycle, in every state: lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]}. This gives period 511 and never reaches zero.
  - Candidate index cand = lfsr[3:0], taken from the pre-shift value.
- States: IDLE, CLEAR, DRAW, DONE.
- IDLE:
  - Outputs hold.
  - in_place=1 -> CLEAR.
- CLEAR (1 cycle):
  - out_mines <= 0, out_count <= 0.
  - -> DRAW.
- DRAW: a candidate is accepted only if cand < CELLS, out_mines[cand]==0, and (with the macro) cand != in_safe.
  - On accept: set out_mines[cand] and increment out_count.
  - Otherwise: reject; no state change except the LFSR.
  - When the post-update count equals MINES -> DONE.
- DONE (1 cycle):
  - out_place_done=1.
  - -> IDLE.
- in_place is ignored outside IDLE. A level held high re-triggers placement after DONE returns to IDLE.
- out_mines holds its value from DONE until the next CLEAR, so the main FSM may sample it at any time in between.

## Timing
- Reset values: out_mines=0, out_place_done=0, out_busy=0, out_count=0, state=IDLE, lfsr=SEED (or 1 if SEED==0).
- Minimum latency: request edge -> out_place_done is MINES+2 cycles (CLEAR + MINES accepting draws + DONE).
- Worst case: bounded by the LFSR period. Every nibble value recurs within 511 cycles, so at most 511*MINES draw cycles.
- out_place_done is high for exactly one cycle. out_busy is low during DONE.
- Reset asserted mid-DRAW: the map clears and the FSM returns to IDLE immediately. No done pulse is produced.
- Simultaneous events:
  - in_place on the DONE cycle is ignored.
  - in_place on the following IDLE cycle starts a new placement.
- in_safe is sampled in every DRAW cycle; the upstream driver holds it stable for the whole placement.
- in_safe >= CELLS excludes no cell.

## Configuration
- MINE_SAFE_CELL_EN:
  - Defined: the in_safe port exists, and that cell is never mined (first-click safety).
  - Undefined: the port is absent and all CELLS cells are eligible.

## Test plan
- Reset with SEED=9'h1A5: check all outputs are 0 and state is IDLE. Release reset, hold in_place=0 for 20 cycles -> outputs unchanged, out_place_done never pulses.
- Pulse in_place with CELLS=9, MINES=3:
  - out_busy rises the next cycle.
  - out_place_done pulses once, no sooner than 5 cycles after the request.
  - Final state: popcount(out_mines)=3, out_count=3, out_mines[8:0] only.
- Repeat with the in_place pulse delayed by 1 cycle -> a different out_mines in general. Identical delay after reset -> identical map (determinism).
- With MINE_SAFE_CELL_EN, in_safe=4: run 200 placements -> out_mines[4]==0 every time and popcount is 3 every time.
- Drop in_restart_n mid-DRAW (out_count=1) -> out_mines=0 and out_count=0 immediately, with no done pulse. A new request then completes normally.
- Hold in_place=1 continuously -> back-to-back placements, each with a single done pulse. CLEAR zeroes the map between them.
